smc_sccb_fsm: RTL and testbench
===============================

# smc_sccb_fsm

SCCB master transmit state machine for 3-phase write transactions. It accepts one write request per handshake: device ID, sub-address and data byte. It drives SIO_C/SIO_D with start condition, 27 serial bits and stop condition, then pulses done. It sits directly downstream of the SCCB timing generator: it enables that generator's half-cycle counter and consumes its mid-half-period tick and end-of-half-period toggle strobes.

## Interface
- DATA_W, 8, width of each transmitted byte; fixed at 8 for SCCB.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  write request valid.
- req_ready_o  out  1  FSM can accept a request; high only in IDLE.
- req_id_i  in  DATA_W  device ID byte; bit0 is transmitted as given (0 = write).
- req_sub_addr_i  in  DATA_W  register sub-address.
- req_data_i  in  DATA_W  write data.
- tick_en_i  in  1  one-cycle strobe at mid half-period, from the timing generator.
- sio_c_tgl_en_i  in  1  one-cycle strobe at end of half-period, from the timing generator.
- cntr_en_o  out  1  enables the timing generator's counter; equals (state != IDLE).
- sio_c_o  out  1  SCCB clock line level, registered.
- sio_d_o  out  1  SCCB data value, registered.
- sio_d_oe_o  out  1  SIO_D output enable, registered; 0 = tri-state.
- busy_o  out  1  transaction in progress; equals ~req_ready_o.
- done_o  out  1  one-cycle pulse after the stop condition completes.

## Operation
- States: IDLE, START, TX, STOP.
- Reset (asynchronous) forces:
  - state IDLE, sio_c_o=1, sio_d_o=1, sio_d_oe_o=1, done_o=0.
  - shift register and counters to 0.
  - Result: req_ready_o=1, busy_o=0, cntr_en_o=0.
- IDLE:
  - Lines held at sio_c_o=1, sio_d_o=1, sio_d_oe_o=1.
  - On req_valid_i & req_ready_o, latch {id, sub, data} into a 24-bit shift register, MSB of id first, then go to START.
  - Request inputs are ignored outside IDLE.
- START (SIO_C high):
  - On tick_en_i: sio_d_o<=0, which is the start condition.
  - On sio_c_tgl_en_i: sio_c_o<=0; bit_cnt<=0, byte_cnt<=0; go to TX.
- TX: each bit is a low half followed by a high half; the current half is given by sio_c_o.
  - Low half, tick_en_i:
    - bit_cnt 0..7: sio_d_oe_o<=1, sio_d_o<=shift MSB.
    - bit_cnt 8 (don't-care bit): sio_d_oe_o<=0, sio_d_o<=0.
  - Low half, sio_c_tgl_en_i: sio_c_o<=1.
  - High half, sio_c_tgl_en_i: sio_c_o<=0.
    - bit_cnt<8: shift left by 1, bit_cnt+1.
    - bit_cnt==8: bit_cnt<=0, byte_cnt+1.
    - bit_cnt==8 and byte_cnt==2: go to STOP.
  - SIO_D is stable for the whole SIO_C-high half.
- STOP:
  - Low half, tick_en_i: sio_d_oe_o<=1, sio_d_o<=0.
  - Low half, sio_c_tgl_en_i: sio_c_o<=1.
  - High half, tick_en_i: sio_d_o<=1, which is the stop condition.
  - High half, sio_c_tgl_en_i: go to IDLE; done_o<=1 for one cycle.
- Counter widths: bit_cnt 4 bits (0..8), byte_cnt 2 bits (0..2).
- Simultaneous tick_en_i and sio_c_tgl_en_i: both actions take effect in the same cycle. The generator must use a half-cycle count H≥4, so this does not occur in legal configurations.
- Strobes arriving while in IDLE are ignored.

## Timing
- Accept at cycle 0. cntr_en_o is high from cycle 1.
- The generator counter starts from 0 at cycle 1, so the Nth toggle strobe arrives at cycle N·H.
- One transaction is 57 half-periods: 1 START + 54 TX + 2 STOP.
- done_o is high in cycle 57·H+1, which is also the first IDLE cycle with req_ready_o=1.
- A request presented in the done_o cycle is accepted in that cycle.
- cntr_en_o is low for at least that cycle, so the generator counter restarts from 0.
- SIO_D changes only at tick_en_i, which falls in mid-half-period. It never changes on the same cycle as SIO_C, except for the start and stop conditions, which change SIO_D while SIO_C is high.
- Reset mid-transaction returns all outputs to their reset values immediately, with no done_o.

## Test plan
- Reset: assert rst_n=0 with random inputs -> sio_c_o=1, sio_d_o=1, sio_d_oe_o=1, req_ready_o=1, cntr_en_o=0, done_o=0.
- Single write, generator H=5 (1 MHz clock, 100 kHz SCCB), id=0x42, sub=0x12, data=0xA5:
  - Sampling SIO_D at SIO_C rising edges yields 0x42, X, 0x12, X, 0xA5, X.
  - Start condition (SIO_D falls while SIO_C=1) seen before the first bit; stop condition (SIO_D rises while SIO_C=1) seen after the last.
  - done_o in cycle 286 after accept.
- Don't-care bits: sio_d_oe_o=0 throughout the high half of bits 9, 18 and 27; 1 in every other half.
- Back-to-back: hold req_valid_i high with a second request 0x43/0x34/0x5A -> second request accepted in the done_o cycle; SIO_C stays 1 between transactions; second frame decodes correctly.
- Busy: change req_*_i every cycle while busy_o=1 -> req_ready_o=0 throughout; transmitted bytes equal the values latched at accept.
- Reset mid-frame: pull rst_n low during byte 2 -> outputs return to idle values immediately; no done_o; a new request after release transmits correctly.

Source files
------------

// File: rtl/smc_sccb_fsm_if.sv
// smc_sccb_fsm_if: write-request handshake between a requester and the SCCB transmit FSM
interface smc_sccb_fsm_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_id;
    logic [DATA_W-1:0] req_sub_addr;
    logic [DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_id,
        output req_sub_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_id,
        input  req_sub_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/smc_sccb_fsm.sv
// smc_sccb_fsm: SCCB master 3-phase write transmitter paced by an external half-cycle timing generator
module smc_sccb_fsm #(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    smc_sccb_fsm_if.slave   req,
    input  logic            tick_en_i,
    input  logic            sio_c_tgl_en_i,
    output logic            cntr_en_o,
    output logic            sio_c_o,
    output logic            sio_d_o,
    output logic            sio_d_oe_o,
    output logic            busy_o,
    output logic            done_o
);
    localparam int SR_W = 3 * DATA_W;

    typedef enum logic [1:0] {IDLE, START, TX, STOP} state_e;

    state_e            state_q, state_d;
    logic              sio_c_q, sio_c_d;
    logic              sio_d_q, sio_d_d;
    logic              sio_d_oe_q, sio_d_oe_d;
    logic              done_q, done_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;

    assign req.req_ready = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign cntr_en_o     = (state_q != IDLE);
    assign sio_c_o       = sio_c_q;
    assign sio_d_o       = sio_d_q;
    assign sio_d_oe_o    = sio_d_oe_q;
    assign done_o        = done_q;

    // Next-state and line values: SIO_D moves on mid-half ticks, SIO_C on end-of-half toggles
    always_comb begin
        state_d    = state_q;
        sio_c_d    = sio_c_q;
        sio_d_d    = sio_d_q;
        sio_d_oe_d = sio_d_oe_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                sio_c_d    = 1'b1;
                sio_d_d    = 1'b1;
                sio_d_oe_d = 1'b1;
                if (req.req_valid) begin
                    shift_d = {req.req_id, req.req_sub_addr, req.req_data};
                    state_d = START;
                end
            end
            START: begin
                if (tick_en_i) sio_d_d = 1'b0;
                if (sio_c_tgl_en_i) begin
                    sio_c_d    = 1'b0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = TX;
                end
            end
            TX: begin
                if (!sio_c_q) begin
                    if (tick_en_i) begin
                        sio_d_oe_d = (bit_cnt_q != 4'd8);
                        sio_d_d    = (bit_cnt_q != 4'd8) ? shift_q[SR_W-1] : 1'b0;
                    end
                    if (sio_c_tgl_en_i) sio_c_d = 1'b1;
                end else if (sio_c_tgl_en_i) begin
                    sio_c_d = 1'b0;
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d  = '0;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = (byte_cnt_q == 2'd2) ? STOP : TX;
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (!sio_c_q) begin
                    if (tick_en_i) begin
                        sio_d_oe_d = 1'b1;
                        sio_d_d    = 1'b0;
                    end
                    if (sio_c_tgl_en_i) sio_c_d = 1'b1;
                end else begin
                    if (tick_en_i) sio_d_d = 1'b1;
                    if (sio_c_tgl_en_i) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered line outputs; reset parks the bus idle with no done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sio_c_q    <= 1'b1;
            sio_d_q    <= 1'b1;
            sio_d_oe_q <= 1'b1;
            done_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sio_c_q    <= sio_c_d;
            sio_d_q    <= sio_d_d;
            sio_d_oe_q <= sio_d_oe_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end
endmodule

// File: tb/tb_smc_sccb_fsm.sv
// tb_smc_sccb_fsm: directed bench with a timeline model of the SCCB write frame
module tb_smc_sccb_fsm;
    localparam int H      = 5;
    localparam int T      = 2;
    localparam int DONE_K = 57 * H + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    smc_sccb_fsm_if #(.DATA_W(8)) bus();
    logic tick_en, tgl_en, cntr_en, sio_c, sio_d, sio_d_oe, busy, done;
    int   cnt = 0;

    smc_sccb_fsm #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus),
        .tick_en_i(tick_en), .sio_c_tgl_en_i(tgl_en),
        .cntr_en_o(cntr_en), .sio_c_o(sio_c), .sio_d_o(sio_d),
        .sio_d_oe_o(sio_d_oe), .busy_o(busy), .done_o(done)
    );

    // Timing generator stand-in: counter restarts whenever the FSM disables it
    always @(posedge clk) cnt <= cntr_en ? ((cnt == H - 1) ? 0 : cnt + 1) : 0;
    assign tick_en = cntr_en && (cnt == T);
    assign tgl_en  = cntr_en && (cnt == H - 1);

    // Model: mk = cycles since the accepting cycle (0 = idle), mf = frame latched at accept
    int          mk = 0;
    logic [23:0] mf = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mk <= 0;
        else if ((mk == 0 || mk == DONE_K) && bus.req_valid) begin
            mk <= 1;
            mf <= {bus.req_id, bus.req_sub_addr, bus.req_data};
        end else if (mk != 0) mk <= (mk == DONE_K) ? 0 : mk + 1;
    end

    // Expected {sio_c, sio_d, oe, done, ready, busy, cntr_en} k cycles after accept.
    // Half p spans k = p*H+1 .. (p+1)*H; its tick result shows from offset T+1.
    // Half 0 is START, halves 1..54 are the low/high pairs of 27 bits, 55/56 are STOP.
    function automatic logic [6:0] expect_at(input int k, input logic [23:0] f);
        int p, o, q, j;
        logic c, d, oe;
        if (k <= 0) return 7'b1110100;
        if (k == DONE_K) return 7'b1111100;
        p  = (k - 1) / H;
        o  = (k - 1) % H;
        c  = (p == 0) || (p % 2 == 0);
        q  = (o >= T + 1) ? p : p - 1;
        if (q >= 1 && q <= 54 && q % 2 == 0) q = q - 1;
        d  = 1'b1;
        oe = 1'b1;
        if (q == 0) d = 1'b0;
        else if (q >= 1 && q <= 54) begin
            j = (q - 1) / 2;
            if (j % 9 == 8) begin
                d  = 1'b0;
                oe = 1'b0;
            end else d = f[23 - (j / 9) * 8 - (j % 9)];
        end else if (q == 55) d = 1'b0;
        return {c, d, oe, 1'b0, 1'b0, 1'b1, 1'b1};
    endfunction

    int   n_cmp = 0, n_bad = 0, cyc = 0;
    logic bits[$];
    logic oes[$];
    int   st = -1, sp = -1, lowoe = 0;
    logic pc = 1'b1, pd = 1'b1, pb = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // One cycle: sample at negedge, decode the bus, compare every output against the model
    task automatic step();
        logic [6:0] g;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            bits.delete(); oes.delete(); st = -1; sp = -1; lowoe = 0;
        end else begin
            if (busy && !pb) begin
                bits.delete(); oes.delete(); st = -1; sp = -1; lowoe = 0;
            end
            if (sio_c && !pc) begin
                bits.push_back(sio_d);
                oes.push_back(sio_d_oe);
            end
            if (pc && sio_c && pd && !sio_d) st = bits.size();
            if (pc && sio_c && !pd && sio_d) sp = bits.size();
            if (busy && sio_c && !sio_d_oe) lowoe++;
        end
        pc = sio_c; pd = sio_d; pb = busy;
        g = {sio_c, sio_d, sio_d_oe, done, bus.req_ready, busy, cntr_en};
        chk($sformatf("cyc%0d_outputs", cyc), 32'(g), 32'(expect_at(mk, mf)));
    endtask

    task automatic drive(input logic v, input logic [23:0] f);
        bus.req_valid = v;
        {bus.req_id, bus.req_sub_addr, bus.req_data} = f;
    endtask

    // Runs one frame already presented; nxt = {valid, frame} shown from cycle 1 and in the done cycle
    task automatic run(input logic [24:0] nxt, input bit scr, output int n);
        n = 0;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (done) begin
                n = c;
                drive(nxt[24], nxt[23:0]);
                break;
            end
            if (scr && busy) drive(1'b1, 24'($urandom));
            else if (c == 1) drive(nxt[24], nxt[23:0]);
        end
    endtask

    task automatic check_frame(input logic [23:0] f);
        logic [7:0]  b[3];
        logic [27:0] m;
        b[0] = '0; b[1] = '0; b[2] = '0; m = '0;
        chk("bit_count", 32'(bits.size()), 32'd28);
        if (bits.size() == 28) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 8; i++) b[k][7-i] = bits[9*k+i];
            for (int i = 0; i < 28; i++) m[i] = oes[i];
        end
        chk("byte_id", 32'(b[0]), 32'(f[23:16]));
        chk("byte_sub", 32'(b[1]), 32'(f[15:8]));
        chk("byte_data", 32'(b[2]), 32'(f[7:0]));
        chk("start_pos", 32'(st), 32'd0);
        chk("stop_pos", 32'(sp), 32'd28);
        chk("oe_at_rise", 32'(m), 32'h0BFDFEFF);
        chk("oe_low_high_cycles", 32'(lowoe), 32'd15);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_sio_c"}, 32'(sio_c), 32'd1);
        chk({nm, "_sio_d"}, 32'(sio_d), 32'd1);
        chk({nm, "_oe"}, 32'(sio_d_oe), 32'd1);
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({nm, "_cntr_en"}, 32'(cntr_en), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        drive(1'b0, 24'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'(($urandom) % 2), 24'($urandom));
            step();
        end
        chk_idle("reset");
        rst_n = 1'b1;
        drive(1'b0, 24'h0);
        step();
        step();

        drive(1'b1, 24'h4212A5);
        run({1'b1, 24'h43345A}, 1'b0, n);
        chk("done_cycle_a", 32'(n), 32'd286);
        chk("done_sio_c_a", 32'(sio_c), 32'd1);
        check_frame(24'h4212A5);

        run({1'b0, 24'h0}, 1'b0, n);
        chk("done_cycle_b", 32'(n), 32'd286);
        check_frame(24'h43345A);

        step(); step(); step();
        drive(1'b1, 24'h81C37E);
        run({1'b0, 24'h0}, 1'b1, n);
        chk("done_cycle_c", 32'(n), 32'd286);
        check_frame(24'h81C37E);

        step();
        drive(1'b1, 24'h6699F0);
        for (int i = 0; i < 140; i++) begin
            step();
            if (i == 0) drive(1'b0, 24'h0);
        end
        #2 rst_n = 1'b0;
        #1 chk_idle("midrst");
        step(); step(); step();
        rst_n = 1'b1;
        step(); step();

        drive(1'b1, 24'h3C5AE1);
        run({1'b0, 24'h0}, 1'b0, n);
        chk("done_cycle_e", 32'(n), 32'd286);
        check_frame(24'h3C5AE1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
